seq_mult_shift_add: RTL and testbench
=====================================

// Module: seq_mult_shift_add
// PURPOSE
//  Multi-cycle unsigned N x N shift-and-add multiplier. Consumes full_adder_nbit:
//  one N-bit add per cycle, Cin tied 0. Start/done handshake; the 2N-bit product
//  is held until the next result overwrites it. Sits downstream of the adder in the ALU datapath.
// PARAMETERS
//  N        4   operand width (>=2); product width is 2N
// PORTS
//  clk      in   1    single clock, rising-edge
//  rst_n    in   1    synchronous reset, active-low
//  start    in   1    request; sampled only when state is IDLE or DONE
//  A        in   N    multiplicand, captured when start is accepted
//  B        in   N    multiplier, captured when start is accepted
//  busy     out  1    high while state is RUN
//  done     out  1    one-cycle pulse; product valid from this cycle on
//  product  out  2N   last completed result, registered
// BEHAVIOUR
//  - Reset: rst_n low at a clk edge -> state=IDLE, busy=0, done=0, product=0,
//    internal M/Q/ACC/cnt=0. Reset in RUN aborts the operation; no done pulse.
//  - States (2-bit): IDLE -> RUN on start; RUN -> RUN while cnt<N-1;
//    RUN -> DONE when cnt==N-1 at the edge; DONE -> RUN on start, else IDLE.
//  - Accept (IDLE/DONE, start=1): M<=A, Q<=B, ACC<=0, cnt<=0, state<=RUN.
//  - RUN step per edge: {C,S} = full_adder_nbit(ACC, Q[0] ? M : 0, Cin=0);
//    {ACC,Q} <= {C,S,Q} >> 1 (the (2N+1)-bit concatenation shifted right by 1;
//    C becomes the MSB of ACC); cnt <= cnt+1.
//  - Exactly N RUN steps. The final step writes product <= {ACC_next,Q_next}
//    and state<=DONE in the same edge.
//  - Latency: start sampled at edge k -> done=1 during the cycle after edge
//    k+N (a registered output). busy=1 for exactly N cycles.
//  - start while RUN: ignored, with no queuing. A/B changes during RUN have no effect.
//  - start during DONE: accepted (back-to-back); done still pulses that cycle;
//    product keeps the old value until the new op completes.
//  - Arithmetic: unsigned, no overflow possible (2N bits hold (2^N-1)^2).
//  - cnt width = $clog2(N); no wrap beyond N-1.
// STRUCTURE
//  - Shared package/include: state encoding localparams ST_IDLE=0, ST_RUN=1,
//    ST_DONE=2. ST=3 is illegal -> next state IDLE.
//  - Sub-module: one full_adder_nbit #(N) instance (existing block). The addend
//    mux, shift registers, counter and FSM are in this module.
// TESTING (N=4; each check made on the done cycle)
//  1. Reset, then A=13,B=11,start 1 cycle -> busy 4 cycles, done 1 cycle, product=143 (0x8F).
//  2. A=15,B=15 -> product=225 (0xE1); A=0,B=9 -> product=0; A=9,B=0 -> 0.
//  3. A=3,B=5 started; start pulsed again with A=7,B=7 on RUN cycle 2
//     -> ignored, product=15, single done.
//  4. Back-to-back: start held high; ops (6x7),(2x8) -> done pulses N+1 cycles apart,
//     product=42 then 16; product stays 42 until the second done.
//  5. A=12,B=12 started; rst_n low on RUN cycle 2 -> next cycle busy=0, done=0,
//     product=0, no later done. A following op (5x5) -> 25.
//  6. Exhaustive: all 256 (A,B) pairs -> product == A*B on every done, plus a
//     latency check (done at edge k+N).

Source files
------------

// File: rtl/seq_mult_shift_add_pkg.sv
// Shared state encoding and small helpers for the shift-and-add multiplier.
package seq_mult_shift_add_pkg;

  localparam int unsigned ST_W = 2;

  // 2-bit FSM encoding; 2'd3 is illegal and recovers to IDLE.
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  // A new request may only be taken while no operation is in flight.
  function automatic logic can_accept(input logic [ST_W-1:0] st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/seq_mult_shift_add_adder.sv
// Ripple-style N-bit adder with carry in/out (existing ALU building block).
module full_adder_nbit #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int unsigned W = N + 1;

  // Widen by one bit so the carry out lands in the MSB.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + W'(cin);

endmodule

// File: rtl/seq_mult_shift_add.sv
// Multi-cycle unsigned N x N shift-and-add multiplier, one add per cycle.
module seq_mult_shift_add
  import seq_mult_shift_add_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = $clog2(N);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;

  logic [N-1:0]  m;
  logic [N-1:0]  q;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;

  logic          accept_c;
  logic          last_c;
  logic [N-1:0]  addend_c;
  logic [N-1:0]  sum_c;
  logic          cout_c;
  logic [N-1:0]  step_acc_c;
  logic [N-1:0]  step_q_c;
  logic [PW-1:0] step_prod_c;

  // Partial-product add: multiplicand enters only when the current multiplier bit is set.
  assign addend_c = q[0] ? m : '0;

  full_adder_nbit #(
    .N (N)
  ) u_add (
    .a    (acc),
    .b    (addend_c),
    .cin  (1'b0),
    .s    (sum_c),
    .cout (cout_c)
  );

  // {C,S,Q} >> 1: carry becomes ACC MSB, sum LSB shifts into the multiplier register.
  assign step_acc_c  = {cout_c, sum_c[N-1:1]};
  assign step_q_c    = {sum_c[0], q[N-1:1]};
  assign step_prod_c = {step_acc_c, step_q_c};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at from IDLE or DONE.
  always_comb begin
    state_nxt = ST_IDLE;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start && can_accept(state)) begin
          accept_c  = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        last_c    = (cnt == CW'(N - 1));
        state_nxt = last_c ? ST_DONE : ST_RUN;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath, counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= (state_nxt == ST_RUN);
      done <= (state == ST_RUN) && last_c;
      if (accept_c) begin
        m   <= A;
        q   <= B;
        acc <= '0;
        cnt <= '0;
      end else if (state == ST_RUN) begin
        acc <= step_acc_c;
        q   <= step_q_c;
        if (last_c) begin
          // Counter parks at N-1; the next accept clears it.
          product <= step_prod_c;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Scoreboard bench for seq_mult_shift_add (N=4).
module tb_seq_mult_shift_add;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 2 * N;

  typedef struct {
    logic [31:0] p;
    int          s;
    int          d;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int          cyc;
  int          n_tests;
  int          n_fail;
  bit          mon_en;
  logic [31:0] hold;
  exp_t        sb[$];

  seq_mult_shift_add #(
    .N (N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (a),
    .B       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Expected result for an op whose start is sampled on the edge after cycle c.
  task automatic push(input logic [31:0] p, input int c);
    exp_t e;
    e.p = p;
    e.s = c + 1;
    e.d = c + 1 + int'(N);
    sb.push_back(e);
  endtask

  // Per-cycle monitor: busy window, done timing, product value and hold.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      logic exp_busy;
      exp_busy = (sb.size() > 0) && (cyc >= sb[0].s) && (cyc < sb[0].d);
      chk("busy", 32'(busy), 32'(exp_busy));
      if (sb.size() > 0 && cyc == sb[0].d) begin
        e = sb.pop_front();
        chk("done", 32'(done), 32'd1);
        chk("product", 32'(product), e.p);
        hold = e.p;
      end else begin
        chk("no_done", 32'(done), 32'd0);
        chk("hold", 32'(product), hold);
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      chk("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge clk); #1;
    a     = x;
    b     = y;
    start = 1'b1;
    push(32'(x) * 32'(y), cyc);
    @(negedge clk); #1;
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    drain();
  endtask

  initial begin
    int c;
    cyc     = 0;
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    hold    = '0;
    rst_n   = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Basic products and zero operands.
    run_op(4'd13, 4'd11);
    run_op(4'd15, 4'd15);
    run_op(4'd0, 4'd9);
    run_op(4'd9, 4'd0);

    // Start during RUN is ignored.
    @(negedge clk); #1;
    a = 4'd3; b = 4'd5; start = 1'b1;
    push(32'd15, cyc);
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    a = 4'd7; b = 4'd7; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    drain();
    repeat (N + 2) @(negedge clk);

    // Back-to-back with start held high through DONE.
    @(negedge clk); #1;
    a = 4'd6; b = 4'd7; start = 1'b1;
    c = cyc;
    push(32'd42, c);
    while (cyc != c + 1 + int'(N)) @(negedge clk);
    #1;
    a = 4'd2; b = 4'd8;
    push(32'd16, cyc);
    while (cyc != c + 2 + 2 * int'(N)) @(negedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (N + 2) @(negedge clk);

    // Reset in the middle of RUN aborts without a done.
    @(negedge clk); #1;
    a = 4'd12; b = 4'd12; start = 1'b1;
    push(32'd144, cyc);
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    hold = '0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    #1;
    rst_n = 1'b1;
    repeat (N + 3) @(negedge clk);
    run_op(4'd5, 4'd5);

    // Every operand pair.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(N'(i), N'(j));
      end
    end
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
